// File: rtl/charge_injection_scan_ctrl_pkg.sv
// Shared definitions for the charge-injection delay-scan sequencer:
// field widths, FSM state encoding and the zero-means-one helpers.
package charge_injection_scan_ctrl_pkg;

  localparam int DELAY_W = 5;   // injection phase, clk1280 steps
  localparam int INJ_W   = 8;   // commands per delay point
  localparam int GAP_W   = 8;   // extra idle cycles after each session
  localparam int PCNT_W  = 6;   // completed delay points (up to 32)
  localparam int CNT_W   = 8;   // shared wait down-counter

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_INJECT = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4,
    ST_NEXT   = 3'd5
  } state_t;

  // A programmed step of zero would never advance the scan; run it as 1.
  function automatic logic [DELAY_W-1:0] eff_step(input logic [DELAY_W-1:0] v);
    return (v == 5'd0) ? 5'd1 : v;
  endfunction

  // A programmed count of zero still issues one command per point.
  function automatic logic [INJ_W-1:0] eff_inj(input logic [INJ_W-1:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/charge_injection_scan_ctrl.sv
// Delay-scan sequencer for the pixel charge-injection pulse generator.
// Sweeps the injection phase from delayStart to delayStop, issuing a fixed
// number of single-cycle commands per point, each followed by a full
// generator session plus an optional gap. One down-counter times the
// SETUP, HOLD and GAP waits. All outputs are registered.
module charge_injection_scan_ctrl
  import charge_injection_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int SESSION_CYCLES = 5
) (
  input  logic               clk40,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delayStart,
  input  logic [DELAY_W-1:0] delayStop,
  input  logic [DELAY_W-1:0] delayStep,
  input  logic [INJ_W-1:0]   injPerStep,
  input  logic [GAP_W-1:0]   gapCycles,
  output logic               chargeInjectionCmd,
  output logic [DELAY_W-1:0] delay,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [INJ_W-1:0]   injCount,
  output logic [PCNT_W-1:0]  pointCount
);

  // Counter reload values: a wait of N cycles loads N-1 and exits at zero.
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SESSION_LOAD = CNT_W'(SESSION_CYCLES - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DELAY_W-1:0]  r_stop;
  logic [DELAY_W-1:0]  r_step;
  logic [INJ_W-1:0]    r_inj_per;
  logic [GAP_W-1:0]    r_gap;
  logic                r_cmd;
  logic [DELAY_W-1:0]  r_delay;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic [INJ_W-1:0]    r_inj_count;
  logic [PCNT_W-1:0]   r_point_count;

  logic [DELAY_W:0]    w_next_delay;
  logic                w_last_point;
  logic                w_more_inj;

  // Next delay point computed one bit wider so a step past 31 is visible.
  always_comb begin
    w_next_delay = {1'b0, r_delay} + {1'b0, r_step};
    w_last_point = w_next_delay[DELAY_W] || (w_next_delay > {1'b0, r_stop});
    w_more_inj   = (r_inj_count < r_inj_per);
  end

  // Scan FSM with shadow configuration, wait counter and registered outputs.
  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_stop        <= 5'd0;
      r_step        <= 5'd0;
      r_inj_per     <= 8'd0;
      r_gap         <= 8'd0;
      r_cmd         <= 1'b0;
      r_delay       <= 5'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_inj_count   <= 8'd0;
      r_point_count <= 6'd0;
    end else begin
      r_cmd     <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if ((r_state != ST_IDLE) && abort) begin
        // Abort wins over every transition, including a pending command.
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_stop        <= delayStop;
              r_step        <= eff_step(delayStep);
              r_inj_per     <= eff_inj(injPerStep);
              r_gap         <= gapCycles;
              r_delay       <= delayStart;
              r_inj_count   <= 8'd0;
              r_point_count <= 6'd0;
              r_busy        <= 1'b1;
              r_cnt         <= SETTLE_LOAD;
              r_state       <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (r_cnt == 8'd0) begin
              r_cmd   <= 1'b1;
              r_state <= ST_INJECT;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_INJECT: begin
            r_inj_count <= r_inj_count + 8'd1;
            r_cnt       <= SESSION_LOAD;
            r_state     <= ST_HOLD;
          end
          ST_HOLD: begin
            if (r_cnt != 8'd0) begin
              r_cnt <= r_cnt - 8'd1;
            end else if (r_gap != 8'd0) begin
              r_cnt   <= r_gap - 8'd1;
              r_state <= ST_GAP;
            end else if (w_more_inj) begin
              r_cmd   <= 1'b1;
              r_state <= ST_INJECT;
            end else begin
              r_state <= ST_NEXT;
            end
          end
          ST_GAP: begin
            if (r_cnt != 8'd0) begin
              r_cnt <= r_cnt - 8'd1;
            end else if (w_more_inj) begin
              r_cmd   <= 1'b1;
              r_state <= ST_INJECT;
            end else begin
              r_state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            r_point_count <= r_point_count + 6'd1;
            if (w_last_point) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_delay     <= w_next_delay[DELAY_W-1:0];
              r_inj_count <= 8'd0;
              r_cnt       <= SETTLE_LOAD;
              r_state     <= ST_SETUP;
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign chargeInjectionCmd = r_cmd;
  assign delay              = r_delay;
  assign busy               = r_busy;
  assign done               = r_done;
  assign aborted            = r_aborted;
  assign injCount           = r_inj_count;
  assign pointCount         = r_point_count;

endmodule
